// File: rtl/nchan_rr_mux_pkg.sv
// Shared definitions for the N-channel round-robin / fixed-select mux:
// mode encodings, output-register FSM states and a small index helper.
package nchan_rr_mux_pkg;

    // Selection mode applied on the mode input
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Output register occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Increment a channel index with wrap at n (idx is always < n)
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/nchan_rr_mux_rr_pick.sv
// Rotating-priority search: returns the first set bit of valid, scanning
// upward from ptr and wrapping NCH-1 -> 0.
module rr_pick #(
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] valid,
    input  logic [CW-1:0]  ptr,
    output logic [CW-1:0]  grant,
    output logic           found
);

    // Channel index examined at each search offset, and whether it is valid
    logic [CW-1:0]  idx_at [NCH];
    logic [NCH-1:0] hit;

    // ptr is always kept below NCH, so one conditional subtract performs the wrap
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_offset
            logic [CW:0] sum;
            assign sum        = {1'b0, ptr} + (CW+1)'(gi);
            assign idx_at[gi] = (sum >= (CW+1)'(NCH)) ? CW'(sum - (CW+1)'(NCH))
                                                      : sum[CW-1:0];
            assign hit[gi]    = valid[idx_at[gi]];
        end
    endgenerate

    // Lowest offset with a hit wins; scanning downward lets it overwrite the rest
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (hit[k]) begin
                grant = idx_at[k];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nchan_rr_mux.sv
// N-channel input mux with a single registered output slot.
// Channels are chosen either by a fixed index (sel) or by rotating
// round-robin priority; the chosen channel is acknowledged combinationally
// in the cycle its word is captured into the output register.
module nchan_rr_mux
    import nchan_rr_mux_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 8,
    parameter int CW  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH*W-1:0] in_data,
    input  logic [NCH-1:0]   in_valid,
    output logic [NCH-1:0]   in_ack,
    input  logic             mode,
    input  logic [CW-1:0]    sel,
    output logic [W-1:0]     out_data,
    output logic [CW-1:0]    out_ch,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t        state_reg, state_next;
    logic [CW-1:0] ptr_reg, ptr_next;
    logic [W-1:0]  data_reg;
    logic [CW-1:0] ch_reg;

    logic [W-1:0]  ch_data [NCH];
    logic [CW-1:0] rr_grant;
    logic          rr_found;
    logic          sel_in_range;
    logic          fix_found;
    logic [CW-1:0] grant_idx;
    logic          grant_found;
    logic          can_load;
    logic          load;

    // Unpack the flat channel bus into per-channel words
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
            assign ch_data[gi] = in_data[gi*W +: W];
        end
    endgenerate

    rr_pick #(
        .NCH (NCH),
        .CW  (CW)
    ) u_rr_pick (
        .valid (in_valid),
        .ptr   (ptr_reg),
        .grant (rr_grant),
        .found (rr_found)
    );

    // Choose the candidate channel for the current mode; an index beyond
    // the channel count never selects anything
    always_comb begin
        sel_in_range = ({1'b0, sel} < (CW+1)'(NCH));
        fix_found    = sel_in_range ? in_valid[sel] : 1'b0;
        if (mode == MODE_RR) begin
            grant_idx   = rr_grant;
            grant_found = rr_found;
        end else begin
            grant_idx   = sel;
            grant_found = fix_found;
        end
    end

    // Next-state logic: the slot can be refilled when empty or when its word
    // leaves this cycle, which keeps back-to-back transfers bubble-free
    always_comb begin
        can_load   = (state_reg == EMPTY) || out_ready;
        load       = can_load && grant_found;
        state_next = state_reg;
        ptr_next   = ptr_reg;
        if (can_load) begin
            state_next = load ? FULL : EMPTY;
        end
        if (load && (mode == MODE_RR)) begin
            ptr_next = CW'(wrap_inc(int'(grant_idx), NCH));
        end
    end

    // Outputs: one-hot accept for the captured channel, silenced during reset
    always_comb begin
        in_ack = '0;
        if (load && rst_n) begin
            in_ack[grant_idx] = 1'b1;
        end
        out_valid = (state_reg == FULL);
        out_data  = data_reg;
        out_ch    = ch_reg;
    end

    // All state: FSM, round-robin pointer and the output word register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            ptr_reg   <= '0;
            data_reg  <= '0;
            ch_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            if (load) begin
                data_reg <= ch_data[grant_idx];
                ch_reg   <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_nchan_rr_mux.sv
// Directed bench for nchan_rr_mux: a 4-channel instance for the main
// behaviour and a 5-channel instance for out-of-range fixed selection.
module tb_nchan_rr_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] in_data;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_ack;
    logic        mode = 1'b0;
    logic [1:0]  sel = '0;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready = 1'b0;

    logic [39:0] in_data5;
    logic [4:0]  in_valid5 = '0;
    logic [4:0]  in_ack5;
    logic        mode5 = 1'b0;
    logic [2:0]  sel5 = '0;
    logic [7:0]  out_data5;
    logic [2:0]  out_ch5;
    logic        out_valid5;
    logic        out_ready5 = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nchan_rr_mux #(.NCH(4), .W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ack(in_ack), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    nchan_rr_mux #(.NCH(5), .W(8)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5),
        .in_ack(in_ack5), .mode(mode5), .sel(sel5), .out_data(out_data5),
        .out_ch(out_ch5), .out_valid(out_valid5), .out_ready(out_ready5)
    );

    // Channel words: ch3=C3 ch2=A5 ch1=11 ch0=5A
    function automatic logic [7:0] exp_data(input int c);
        case (c)
            0: return 8'h5A;
            1: return 8'h11;
            2: return 8'hA5;
            default: return 8'hC3;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 4'b1111;
        #1;
        checks++; if (in_ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", in_ack); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
        checks++; if (out_ch !== 2'd0) begin failures++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
        $display("reset: ack=%b valid=%b data=%h ch=%0d", in_ack, out_valid, out_data, out_ch);
        do_reset();
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        #1;
        checks++; if (in_ack !== 4'b0100) begin failures++; $display("FAIL fixed_ack got=%b exp=0100", in_ack); end
        @(posedge clk); #1;
        checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL fixed_data got=%h exp=a5", out_data); end
        checks++; if (out_ch !== 2'd2) begin failures++; $display("FAIL fixed_ch got=%0d exp=2", out_ch); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fixed_valid got=%b exp=1", out_valid); end
        $display("fixed: ch=%0d data=%h valid=%b", out_ch, out_data, out_valid);
        // sel points at an idle channel: nothing accepted, slot drains and keeps last word
        @(negedge clk);
        sel = 2'd1; in_valid = 4'b0100;
        #1;
        checks++; if (in_ack !== 4'b0000) begin failures++; $display("FAIL fixed_idle_ack got=%b exp=0000", in_ack); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'hA5 || out_ch !== 2'd2) begin failures++; $display("FAIL drain_retain got=%h/%0d exp=a5/2", out_data, out_ch); end
        $display("drain: valid=%b data=%h ch=%0d", out_valid, out_data, out_ch);
    endtask

    task automatic test_rr_sequence();
        do_reset();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (out_ch !== 2'(i % 4)) begin failures++; $display("FAIL rr_seq_ch[%0d] got=%0d exp=%0d", i, out_ch, i % 4); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rr_seq_valid[%0d] got=%b exp=1", i, out_valid); end
            checks++; if (out_data !== exp_data(i % 4)) begin failures++; $display("FAIL rr_seq_data[%0d] got=%h exp=%h", i, out_data, exp_data(i % 4)); end
            $display("rr_seq: xfer %0d ch=%0d data=%h", i, out_ch, out_data);
        end
    endtask

    task automatic test_rr_wrap();
        do_reset();
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0100;
        @(posedge clk);            // grants ch2, pointer moves to 3
        @(negedge clk);
        in_valid = 4'b0010;
        #1;
        checks++; if (in_ack !== 4'b0010) begin failures++; $display("FAIL wrap_ack got=%b exp=0010", in_ack); end
        @(posedge clk); #1;
        checks++; if (out_ch !== 2'd1) begin failures++; $display("FAIL wrap_ch got=%0d exp=1", out_ch); end
        @(negedge clk);
        in_valid = 4'b1111;
        #1;
        checks++; if (in_ack !== 4'b0100) begin failures++; $display("FAIL wrap_ptr_ack got=%b exp=0100", in_ack); end
        $display("rr_wrap: ch=%0d next_ack=%b", out_ch, in_ack);
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
        #1;
        checks++; if (in_ack !== 4'b0001) begin failures++; $display("FAIL bp_first_ack got=%b exp=0001", in_ack); end
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (in_ack !== 4'b0000) begin failures++; $display("FAIL bp_ack[%0d] got=%b exp=0000", i, in_ack); end
            checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h5A) begin failures++; $display("FAIL bp_hold[%0d] got=%b/%0d/%h exp=1/0/5a", i, out_valid, out_ch, out_data); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ack !== 4'b0010) begin failures++; $display("FAIL bp_release_ack got=%b exp=0010", in_ack); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h11) begin failures++; $display("FAIL bp_reload got=%b/%0d/%h exp=1/1/11", out_valid, out_ch, out_data); end
        $display("backpressure: reload ch=%0d data=%h", out_ch, out_data);
    endtask

    task automatic test_mode_switch();
        do_reset();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        @(posedge clk);            // ch0 loaded, pointer at 1
        @(negedge clk);
        mode = 1'b0; sel = 2'd3;
        #1;
        checks++; if (in_ack !== 4'b1000) begin failures++; $display("FAIL sw_fixed_ack got=%b exp=1000", in_ack); end
        @(posedge clk); #1;
        checks++; if (out_ch !== 2'd3 || out_data !== 8'hC3) begin failures++; $display("FAIL sw_fixed_out got=%0d/%h exp=3/c3", out_ch, out_data); end
        @(negedge clk);
        mode = 1'b1;
        #1;
        checks++; if (in_ack !== 4'b0010) begin failures++; $display("FAIL sw_rr_ptr_hold got=%b exp=0010", in_ack); end
        $display("mode_switch: fixed ch=%0d then rr ack=%b", out_ch, in_ack);
    endtask

    task automatic test_fixed_oob();
        @(negedge clk);
        in_data5 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h66};
        mode5 = 1'b0; sel5 = 3'd5; in_valid5 = 5'b11111; out_ready5 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ack5 !== 5'b00000) begin failures++; $display("FAIL oob_ack[%0d] got=%b exp=00000", i, in_ack5); end
            @(posedge clk); #1;
            checks++; if (out_valid5 !== 1'b0) begin failures++; $display("FAIL oob_valid[%0d] got=%b exp=0", i, out_valid5); end
            @(negedge clk);
        end
        sel5 = 3'd4;
        #1;
        checks++; if (in_ack5 !== 5'b10000) begin failures++; $display("FAIL top_ch_ack got=%b exp=10000", in_ack5); end
        @(posedge clk); #1;
        checks++; if (out_valid5 !== 1'b1 || out_ch5 !== 3'd4 || out_data5 !== 8'h55) begin failures++; $display("FAIL top_ch_out got=%b/%0d/%h exp=1/4/55", out_valid5, out_ch5, out_data5); end
        $display("fixed_oob: sel=5 ignored, sel=4 ch=%0d data=%h", out_ch5, out_data5);
        @(negedge clk);
        in_valid5 = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);            // ch2 now held
        #3;
        rst_n = 1'b0;              // mid-cycle, no clock edge involved
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin failures++; $display("FAIL async_clear got=%b/%h/%0d exp=0/00/0", out_valid, out_data, out_ch); end
        checks++; if (in_ack !== 4'b0000) begin failures++; $display("FAIL async_ack got=%b exp=0000", in_ack); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h5A) begin failures++; $display("FAIL async_restart got=%b/%0d/%h exp=1/0/5a", out_valid, out_ch, out_data); end
        $display("async_reset: restart ch=%0d data=%h", out_ch, out_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        in_data  = {8'hC3, 8'hA5, 8'h11, 8'h5A};
        in_data5 = '0;
        test_reset();
        test_fixed();
        test_rr_sequence();
        test_rr_wrap();
        test_backpressure();
        test_mode_switch();
        test_fixed_oob();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
